// File: rtl/tlb_pkg.sv
// Shared TLB types and CP0 field helpers for the joint TLB.
// Optional build macro TLB_PAGEMASK_EN enables variable page sizes.
package tlb_pkg;

  localparam int TLB_NUM_ENTRIES = 32;
  localparam int TLB_IDXBITS     = 5;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [11:0] mask;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef struct packed {
    logic [31:0] paddr;
    logic        miss;
    logic        invalid;
    logic        dirty;
    logic        cached;
  } tlb_result_t;

  function automatic logic [19:0] entrylo_pfn(input logic [31:0] lo);
    return lo[25:6];
  endfunction

  function automatic logic [2:0] entrylo_c(input logic [31:0] lo);
    return lo[5:3];
  endfunction

  function automatic logic entrylo_d(input logic [31:0] lo);
    return lo[2];
  endfunction

  function automatic logic entrylo_v(input logic [31:0] lo);
    return lo[1];
  endfunction

  function automatic logic entrylo_g(input logic [31:0] lo);
    return lo[0];
  endfunction

  function automatic logic [18:0] entryhi_vpn2(input logic [31:0] hi);
    return hi[31:13];
  endfunction

  function automatic logic [7:0] entryhi_asid(input logic [31:0] hi);
    return hi[7:0];
  endfunction

  // Page size exponent above 4 KB: number of set bits in the PageMask field.
  function automatic logic [3:0] mask_ones(input logic [11:0] m);
    logic [3:0] n;
    n = '0;
    for (int b = 0; b < 12; b++) n = n + {3'b000, m[b]};
    return n;
  endfunction

endpackage

// File: rtl/tlb_lookup.sv
// Associative match, lowest-index priority select and odd/even page half
// selection; page size honours the entry mask only with TLB_PAGEMASK_EN.
module tlb_lookup
  import tlb_pkg::*;
#(
  parameter int TLB_ENTRIES = TLB_NUM_ENTRIES,
  parameter int IDXBITS     = TLB_IDXBITS
) (
  input  tlb_entry_t               entries_i [TLB_ENTRIES],
  input  logic [TLB_ENTRIES-1:0]   present_i,
  input  logic [31:0]              vaddr_i,
  input  logic [7:0]               asid_i,
  output logic                     hit_o,
  output logic [IDXBITS-1:0]       idx_o,
  output logic [31:0]              paddr_o,
  output logic [2:0]               c_o,
  output logic                     d_o,
  output logic                     v_o
);

  function automatic logic [11:0] eff_mask(input tlb_entry_t e);
`ifdef TLB_PAGEMASK_EN
    return e.mask;
`else
    return 12'h000;
`endif
  endfunction

  logic [TLB_ENTRIES-1:0] match;
  tlb_entry_t             ent;
  logic [3:0]             k;
  logic [4:0]             sel_bit;
  logic                   odd;
  logic [31:0]            low_mask;
  logic [19:0]            pfn;

  always_comb begin
    match = '0;
    for (int e = 0; e < TLB_ENTRIES; e++) begin
      match[e] = present_i[e]
               && (((entries_i[e].vpn2 ^ vaddr_i[31:13]) & ~{7'b0, eff_mask(entries_i[e])}) == 19'b0)
               && (entries_i[e].g || (entries_i[e].asid == asid_i));
    end
  end

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    idx_o = '0;
    for (int e = TLB_ENTRIES - 1; e >= 0; e--) begin
      if (match[e]) idx_o = IDXBITS'(e);
    end
    hit_o = |match;
  end

  always_comb begin
    ent      = entries_i[idx_o];
    k        = mask_ones(eff_mask(ent));
    sel_bit  = 5'd12 + {1'b0, k};
    odd      = vaddr_i[sel_bit];
    low_mask = ~(32'hFFFF_FFFF << sel_bit);
    pfn      = odd ? ent.pfn1 : ent.pfn0;
    c_o      = odd ? ent.c1   : ent.c0;
    d_o      = odd ? ent.d1   : ent.d0;
    v_o      = odd ? ent.v1   : ent.v0;
    paddr_o  = ({pfn, 12'b0} & ~low_mask) | (vaddr_i & low_mask);
  end

endmodule

// File: rtl/tlb.sv
// Joint MIPS32 TLB: CP0 TLBWI/TLBWR/TLBR/TLBP support plus instruction and
// data lookup ports with one-cycle latency. Build macro: TLB_PAGEMASK_EN.
module tlb
  import tlb_pkg::*;
#(
  parameter int TLB_ENTRIES = TLB_NUM_ENTRIES,
  parameter int IDXBITS     = TLB_IDXBITS
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] index,
  input  logic [31:0] random,
  input  logic [31:0] entrylo0,
  input  logic [31:0] entrylo1,
  input  logic [31:0] entryhi,
  input  logic [11:0] mask,
  input  logic        tlbwi,
  input  logic        tlbwr,
  output logic [31:0] tlbr_lo0,
  output logic [31:0] tlbr_lo1,
  output logic [31:0] tlbr_hi,
  output logic [11:0] tlbr_mask,
  output logic [31:0] tlbp_index,
  input  logic        i_req,
  input  logic [31:0] i_vaddr,
  output logic        i_rvalid,
  output logic [31:0] i_paddr,
  output logic        i_miss,
  output logic        i_invalid,
  output logic        i_dirty,
  output logic        i_cached,
  input  logic        d_req,
  input  logic [31:0] d_vaddr,
  output logic        d_rvalid,
  output logic [31:0] d_paddr,
  output logic        d_miss,
  output logic        d_invalid,
  output logic        d_dirty,
  output logic        d_cached
);

  tlb_entry_t             entries_q [TLB_ENTRIES];
  logic [TLB_ENTRIES-1:0] present_q, present_d;
  logic                   we;
  logic [IDXBITS-1:0]     widx;
  tlb_entry_t             wentry;
  tlb_entry_t             rentry;

  always_comb begin
    we          = tlbwi | tlbwr;
    widx        = tlbwi ? index[IDXBITS-1:0] : random[IDXBITS-1:0];
    wentry.vpn2 = entryhi_vpn2(entryhi);
    wentry.asid = entryhi_asid(entryhi);
    wentry.g    = entrylo_g(entrylo0) & entrylo_g(entrylo1);
`ifdef TLB_PAGEMASK_EN
    wentry.mask = mask;
`else
    wentry.mask = 12'h000;
`endif
    wentry.pfn0 = entrylo_pfn(entrylo0);
    wentry.c0   = entrylo_c(entrylo0);
    wentry.d0   = entrylo_d(entrylo0);
    wentry.v0   = entrylo_v(entrylo0);
    wentry.pfn1 = entrylo_pfn(entrylo1);
    wentry.c1   = entrylo_c(entrylo1);
    wentry.d1   = entrylo_d(entrylo1);
    wentry.v1   = entrylo_v(entrylo1);
    present_d   = present_q;
    if (we) present_d[widx] = 1'b1;
  end

  // Reset only invalidates; stored fields keep whatever they held.
  always_ff @(posedge clk) begin
    if (!resetn) present_q <= '0;
    else         present_q <= present_d;
  end

  always_ff @(posedge clk) begin
    if (we) entries_q[widx] <= wentry;
  end

  always_comb begin
    rentry   = entries_q[index[IDXBITS-1:0]];
    tlbr_hi  = {rentry.vpn2, 5'b0, rentry.asid};
    tlbr_lo0 = {6'b0, rentry.pfn0, rentry.c0, rentry.d0, rentry.v0, rentry.g};
    tlbr_lo1 = {6'b0, rentry.pfn1, rentry.c1, rentry.d1, rentry.v1, rentry.g};
`ifdef TLB_PAGEMASK_EN
    tlbr_mask = rentry.mask;
`else
    tlbr_mask = 12'h000;
`endif
  end

  logic               p_hit, i_hit, d_hit;
  logic [IDXBITS-1:0] p_idx, i_idx, d_idx;
  logic [31:0]        p_pa, i_pa, d_pa;
  logic [2:0]         p_c, i_c, d_c;
  logic               p_d, i_d, d_d;
  logic               p_v, i_v, d_v;

  tlb_lookup #(.TLB_ENTRIES(TLB_ENTRIES), .IDXBITS(IDXBITS)) u_probe (
    .entries_i(entries_q), .present_i(present_q), .vaddr_i(entryhi),
    .asid_i(entryhi[7:0]), .hit_o(p_hit), .idx_o(p_idx), .paddr_o(p_pa),
    .c_o(p_c), .d_o(p_d), .v_o(p_v)
  );

  tlb_lookup #(.TLB_ENTRIES(TLB_ENTRIES), .IDXBITS(IDXBITS)) u_ilook (
    .entries_i(entries_q), .present_i(present_q), .vaddr_i(i_vaddr),
    .asid_i(entryhi[7:0]), .hit_o(i_hit), .idx_o(i_idx), .paddr_o(i_pa),
    .c_o(i_c), .d_o(i_d), .v_o(i_v)
  );

  tlb_lookup #(.TLB_ENTRIES(TLB_ENTRIES), .IDXBITS(IDXBITS)) u_dlook (
    .entries_i(entries_q), .present_i(present_q), .vaddr_i(d_vaddr),
    .asid_i(entryhi[7:0]), .hit_o(d_hit), .idx_o(d_idx), .paddr_o(d_pa),
    .c_o(d_c), .d_o(d_d), .v_o(d_v)
  );

  assign tlbp_index = p_hit ? {{(32-IDXBITS){1'b0}}, p_idx} : 32'h8000_0000;

  // kseg0/kseg1 bypass translation; everything else goes through the array.
  function automatic tlb_result_t port_result(input logic [31:0] va, input logic hit,
                                              input logic [31:0] pa, input logic [2:0] c,
                                              input logic d, input logic v);
    tlb_result_t r;
    r = '0;
    if (va[31:30] == 2'b10) begin
      r.paddr  = {3'b000, va[28:0]};
      r.cached = ~va[29];
    end else if (hit) begin
      r.paddr   = pa;
      r.invalid = ~v;
      r.dirty   = d;
      r.cached  = (c == 3'd3);
    end else begin
      r.miss = 1'b1;
    end
    return r;
  endfunction

  logic        i_rvalid_q, d_rvalid_q;
  tlb_result_t i_res_q, i_res_d, d_res_q, d_res_d;

  assign i_res_d = i_req ? port_result(i_vaddr, i_hit, i_pa, i_c, i_d, i_v) : i_res_q;
  assign d_res_d = d_req ? port_result(d_vaddr, d_hit, d_pa, d_c, d_d, d_v) : d_res_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_res_q    <= '0;
      d_res_q    <= '0;
    end else begin
      i_rvalid_q <= i_req;
      d_rvalid_q <= d_req;
      i_res_q    <= i_res_d;
      d_res_q    <= d_res_d;
    end
  end

  assign i_rvalid  = i_rvalid_q;
  assign i_paddr   = i_res_q.paddr;
  assign i_miss    = i_res_q.miss;
  assign i_invalid = i_res_q.invalid;
  assign i_dirty   = i_res_q.dirty;
  assign i_cached  = i_res_q.cached;
  assign d_rvalid  = d_rvalid_q;
  assign d_paddr   = d_res_q.paddr;
  assign d_miss    = d_res_q.miss;
  assign d_invalid = d_res_q.invalid;
  assign d_dirty   = d_res_q.dirty;
  assign d_cached  = d_res_q.cached;

  logic unused_bits;
  assign unused_bits = ^{index[31:IDXBITS], random[31:IDXBITS], entrylo0[31:26],
                         entrylo1[31:26], entryhi[12:8], mask, i_idx, d_idx,
                         p_pa, p_c, p_d, p_v};

endmodule

// File: tb/tb_tlb.sv
// Self-checking bench for tlb: vector table plus hand-written corner sequences,
// with per-port expectation queues popped as results appear.
module tb_tlb;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] index, random, entrylo0, entrylo1, entryhi;
  logic [11:0] mask;
  logic        tlbwi, tlbwr;
  logic [31:0] tlbr_lo0, tlbr_lo1, tlbr_hi, tlbp_index;
  logic [11:0] tlbr_mask;
  logic        i_req, d_req;
  logic [31:0] i_vaddr, d_vaddr, i_paddr, d_paddr;
  logic        i_rvalid, i_miss, i_invalid, i_dirty, i_cached;
  logic        d_rvalid, d_miss, d_invalid, d_dirty, d_cached;

  tlb dut (
    .clk(clk), .resetn(resetn), .index(index), .random(random),
    .entrylo0(entrylo0), .entrylo1(entrylo1), .entryhi(entryhi), .mask(mask),
    .tlbwi(tlbwi), .tlbwr(tlbwr), .tlbr_lo0(tlbr_lo0), .tlbr_lo1(tlbr_lo1),
    .tlbr_hi(tlbr_hi), .tlbr_mask(tlbr_mask), .tlbp_index(tlbp_index),
    .i_req(i_req), .i_vaddr(i_vaddr), .i_rvalid(i_rvalid), .i_paddr(i_paddr),
    .i_miss(i_miss), .i_invalid(i_invalid), .i_dirty(i_dirty), .i_cached(i_cached),
    .d_req(d_req), .d_vaddr(d_vaddr), .d_rvalid(d_rvalid), .d_paddr(d_paddr),
    .d_miss(d_miss), .d_invalid(d_invalid), .d_dirty(d_dirty), .d_cached(d_cached)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          port;
    logic [31:0] va;
    logic [31:0] pa;
    logic        miss, inv, dirty, cached;
  } vec_t;

  typedef struct {
    logic [31:0] pa;
    logic        miss, inv, dirty, cached;
  } exp_t;

  exp_t iq[$];
  exp_t dq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(input bit port, input logic [31:0] va, input logic [31:0] pa,
                       input logic m, input logic iv, input logic dt, input logic ca);
    exp_t e;
    e.pa = pa; e.miss = m; e.inv = iv; e.dirty = dt; e.cached = ca;
    if (!port) begin
      i_req = 1'b1; i_vaddr = va; iq.push_back(e);
    end else begin
      d_req = 1'b1; d_vaddr = va; dq.push_back(e);
    end
  endtask

  task automatic collect();
    exp_t e;
    if (iq.size() > 0) begin
      chk("i_rvalid", i_rvalid, 1);
      if (i_rvalid) begin
        e = iq.pop_front();
        chk("i_paddr", i_paddr, e.pa);
        chk("i_miss", i_miss, e.miss);
        chk("i_invalid", i_invalid, e.inv);
        chk("i_dirty", i_dirty, e.dirty);
        chk("i_cached", i_cached, e.cached);
      end
    end else chk("i_rvalid_idle", i_rvalid, 0);
    if (dq.size() > 0) begin
      chk("d_rvalid", d_rvalid, 1);
      if (d_rvalid) begin
        e = dq.pop_front();
        chk("d_paddr", d_paddr, e.pa);
        chk("d_miss", d_miss, e.miss);
        chk("d_invalid", d_invalid, e.inv);
        chk("d_dirty", d_dirty, e.dirty);
        chk("d_cached", d_cached, e.cached);
      end
    end else chk("d_rvalid_idle", d_rvalid, 0);
    iq.delete();
    dq.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    i_req = 1'b0;
    d_req = 1'b0;
    collect();
  endtask

  task automatic wr(input bit wi, input bit wrr, input logic [31:0] idx, input logic [31:0] rnd,
                    input logic [31:0] hi, input logic [31:0] lo0, input logic [31:0] lo1,
                    input logic [11:0] m);
    index = idx; random = rnd; entryhi = hi; entrylo0 = lo0; entrylo1 = lo1; mask = m;
    tlbwi = wi; tlbwr = wrr;
    step();
    tlbwi = 1'b0; tlbwr = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b1, 32'h0040_0ABC, 32'h0004_0ABC, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 32'h0040_1000, 32'h0004_0000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 32'hBFC0_0000, 32'h1FC0_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 32'h8000_1000, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 32'h0060_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 32'h0040_0FFF, 32'h0004_0FFF, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 32'hC040_0ABC, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 32'hA000_0010, 32'h0000_0010, 1'b0, 1'b0, 1'b0, 1'b0};

    resetn = 1'b0; index = '0; random = '0; entrylo0 = '0; entrylo1 = '0;
    entryhi = '0; mask = '0; tlbwi = 1'b0; tlbwr = 1'b0;
    i_req = 1'b0; d_req = 1'b0; i_vaddr = '0; d_vaddr = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_i_rvalid", i_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_i_paddr", i_paddr, 0);
    chk("rst_d_flags", {d_miss, d_invalid, d_dirty, d_cached}, 0);
    resetn = 1'b1;

    // Empty array: refill and probe failure
    entryhi = 32'h0040_0005;
    issue(0, 32'h0040_0000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("tlbp_empty", tlbp_index, 32'h8000_0000);

    wr(1, 0, 3, 0, 32'h0040_0005, 32'h0000_101E, 32'h0000_1018, 12'h000);
    #1;
    chk("tlbr_hi_3", tlbr_hi, 32'h0040_0005);
    chk("tlbr_lo0_3", tlbr_lo0, 32'h0000_101E);
    chk("tlbr_lo1_3", tlbr_lo1, 32'h0000_1018);
    chk("tlbp_3", tlbp_index, 32'h0000_0003);

    // Back-to-back table vectors across both ports
    for (int n = 0; n < 8; n++) begin
      issue(vecs[n].port, vecs[n].va, vecs[n].pa, vecs[n].miss, vecs[n].inv,
            vecs[n].dirty, vecs[n].cached);
      step();
    end

    // Both ports hitting the same entry together, then hold while idle
    issue(0, 32'h0040_0ABC, 32'h0004_0ABC, 1'b0, 1'b0, 1'b1, 1'b1);
    issue(1, 32'h0040_0123, 32'h0004_0123, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    step();
    chk("d_hold_paddr", d_paddr, 32'h0004_0123);
    chk("i_hold_paddr", i_paddr, 32'h0004_0ABC);

    // ASID mismatch with G=0, then global rewrite
    entryhi = 32'h0040_0006;
    issue(1, 32'h0040_0ABC, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("tlbp_asid_miss", tlbp_index, 32'h8000_0000);
    wr(1, 0, 3, 0, 32'h0040_0005, 32'h0000_101F, 32'h0000_1019, 12'h000);
    entryhi = 32'h0040_0006;
    #1;
    chk("tlbr_lo0_g", tlbr_lo0, 32'h0000_101F);
    chk("tlbr_lo1_g", tlbr_lo1, 32'h0000_1019);
    chk("tlbp_global", tlbp_index, 32'h0000_0003);
    issue(1, 32'h0040_0ABC, 32'h0004_0ABC, 1'b0, 1'b0, 1'b1, 1'b1);
    step();

    // Duplicate VPN2 at 7 and 2: lowest index wins
    wr(1, 0, 7, 0, 32'h0080_0001, 32'h0000_1DDF, 32'h0000_1DDF, 12'h000);
    wr(1, 0, 2, 0, 32'h0080_0001, 32'h0000_089F, 32'h0000_089F, 12'h000);
    #1;
    chk("tlbp_prio", tlbp_index, 32'h0000_0002);
    issue(0, 32'h0080_0123, 32'h0002_2123, 1'b0, 1'b0, 1'b1, 1'b1);
    step();

    // TLBWR alone, then TLBWI+TLBWR together
    wr(0, 1, 0, 10, 32'h00C0_0001, 32'h0000_0C1F, 32'h0000_0C1F, 12'h000);
    index = 10; #1;
    chk("tlbwr_hi", tlbr_hi, 32'h00C0_0001);
    chk("tlbwr_lo0", tlbr_lo0, 32'h0000_0C1F);
    wr(1, 1, 9, 10, 32'h00A0_0001, 32'h0000_155F, 32'h0000_155F, 12'h000);
    index = 10; #1;
    chk("both_rand_kept", tlbr_hi, 32'h00C0_0001);
    index = 9; #1;
    chk("both_idx_hi", tlbr_hi, 32'h00A0_0001);
    chk("both_tlbp", tlbp_index, 32'h0000_0009);

    // Lookup in the write cycle sees old contents
    index = 4; entryhi = 32'h00E0_0001; entrylo0 = 32'h0000_0E1F; entrylo1 = 32'h0000_0E1F;
    mask = 12'h000;
    issue(1, 32'h00E0_0010, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    tlbwi = 1'b1;
    step();
    tlbwi = 1'b0;
    issue(1, 32'h00E0_0010, 32'h0003_8010, 1'b0, 1'b0, 1'b1, 1'b1);
    step();

    // 16 KB page at index 5
    wr(1, 0, 5, 0, 32'h0100_0001, 32'h0000_401F, 32'h0000_811F, 12'h003);
    #1;
`ifdef TLB_PAGEMASK_EN
    chk("tlbr_mask", tlbr_mask, 12'h003);
    issue(1, 32'h0100_6004, 32'h0020_6004, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    issue(0, 32'h0100_1004, 32'h0010_1004, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
`else
    chk("tlbr_mask", tlbr_mask, 12'h000);
    issue(1, 32'h0100_6004, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    issue(0, 32'h0100_1004, 32'h0020_4004, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
`endif

    // Reset while a lookup is pending drops it and invalidates the array
    i_req = 1'b1; i_vaddr = 32'h0040_0ABC; resetn = 1'b0;
    @(posedge clk); #1;
    i_req = 1'b0;
    chk("rst_mid_rvalid", i_rvalid, 0);
    chk("rst_mid_paddr", i_paddr, 0);
    resetn = 1'b1;
    entryhi = 32'h0040_0006;
    #1;
    chk("rst_tlbp", tlbp_index, 32'h8000_0000);
    issue(0, 32'h0040_0ABC, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
